// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: walks (neuron, chunk) pairs over a LENGTH-lane multiplier and accumulates per-neuron dot products
module fc_layer_sequencer #(
  parameter int BITWIDTH = 8,
  parameter int LENGTH = 16,
  parameter int IN_LEN = 64,
  parameter int OUT_LEN = 10,
  localparam int CHUNKS = IN_LEN / LENGTH,
  localparam int PW = 2 * BITWIDTH,
  localparam int ACC_W = PW + $clog2(IN_LEN),
  localparam int AW = $clog2(OUT_LEN * CHUNKS) > 0 ? $clog2(OUT_LEN * CHUNKS) : 1,
  localparam int CW = $clog2(CHUNKS) > 0 ? $clog2(CHUNKS) : 1,
  localparam int NW = $clog2(OUT_LEN) > 0 ? $clog2(OUT_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          w_addr,
  output logic                   w_rd_en,
  output logic [CW-1:0]          x_sel,
  output logic                   mult_ena,
  input  logic [LENGTH*PW-1:0]   prod_in,
  output logic [ACC_W-1:0]       res_data,
  output logic [NW-1:0]          res_idx,
  output logic                   res_valid
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;
  logic [NW-1:0] neuron, n1, n2;
  logic f1, l1, v2, f2, l2;
  logic signed [ACC_W-1:0] acc, lane_sum;
  logic last_chunk, last_pair;
  assign last_chunk = x_sel == CW'(CHUNKS - 1);
  assign last_pair = last_chunk && neuron == NW'(OUT_LEN - 1);
  assign busy = state == S_RUN || state == S_DRAIN;
  assign done = state == S_DONE;
  assign res_data = acc;
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LENGTH; i++) lane_sum = lane_sum + ACC_W'($signed(prod_in[i*PW +: PW]));
  end
  always_comb begin
    state_nx = state == S_IDLE  ? (start ? S_RUN : S_IDLE) :
               state == S_RUN   ? (last_pair ? S_DRAIN : S_RUN) :
               state == S_DRAIN ? (res_valid && !mult_ena && !v2 ? S_DONE : S_DRAIN) :
                                  S_IDLE;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      w_rd_en <= 1'b0;
      w_addr <= '0;
      x_sel <= '0;
      neuron <= '0;
      mult_ena <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      n1 <= '0;
      v2 <= 1'b0;
      f2 <= 1'b0;
      l2 <= 1'b0;
      n2 <= '0;
      acc <= '0;
      res_valid <= 1'b0;
      res_idx <= '0;
    end else begin
      w_rd_en <= state_nx == S_RUN;
      w_addr <= state == S_RUN ? w_addr + 1'b1 : '0;
      x_sel <= state == S_RUN && !last_chunk ? x_sel + 1'b1 : '0;
      neuron <= state != S_RUN ? '0 : last_chunk ? neuron + 1'b1 : neuron;
      mult_ena <= w_rd_en;
      f1 <= x_sel == '0;
      l1 <= last_chunk;
      n1 <= neuron;
      v2 <= mult_ena;
      f2 <= f1;
      l2 <= l1;
      n2 <= n1;
      if (v2) acc <= f2 ? lane_sum : acc + lane_sum;
      res_valid <= v2 && l2;
      res_idx <= n2;
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: randomized self-checking bench with ROM/multiplier environment and dot-product reference
module tb_fc_layer_sequencer;
  localparam int BW = 8, LEN = 16, INL = 64, OUTL = 10, CH = INL / LEN, N = OUTL * CH, PW = 2 * BW;
  localparam int AW = 6, CW = 2, NW = 4, ACC_W = 22;
  logic clk = 0, rst = 1, start = 0, start1 = 0;
  logic busy, done, w_rd_en, mult_ena, res_valid;
  logic [AW-1:0] w_addr;
  logic [CW-1:0] x_sel;
  logic [NW-1:0] res_idx;
  logic [ACC_W-1:0] res_data;
  logic [LEN*PW-1:0] prod = '0, prod1 = '0, nx, nx1;
  logic busy1, done1, w_rd_en1, mult_ena1, res_valid1;
  logic [0:0] w_addr1, x_sel1, res_idx1;
  logic [19:0] res_data1;
  int xv[INL];
  int wv[OUTL][INL];
  longint expv[OUTL];
  int checks = 0, failures = 0;
  int wq = 0, xq = 0;
  fc_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .w_addr(w_addr),
    .w_rd_en(w_rd_en), .x_sel(x_sel), .mult_ena(mult_ena), .prod_in(prod),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid)
  );
  fc_layer_sequencer #(.LENGTH(16), .IN_LEN(16), .OUT_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .w_addr(w_addr1),
    .w_rd_en(w_rd_en1), .x_sel(x_sel1), .mult_ena(mult_ena1), .prod_in(prod1),
    .res_data(res_data1), .res_idx(res_idx1), .res_valid(res_valid1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    for (int l = 0; l < LEN; l++)
      nx[l*PW +: PW] = mult_ena ? PW'(xv[xq*LEN+l] * wv[wq/CH][(wq%CH)*LEN+l]) : PW'($urandom);
    for (int l = 0; l < LEN; l++)
      nx1[l*PW +: PW] = mult_ena1 ? PW'(2 * 3) : PW'($urandom);
    prod <= nx;
    prod1 <= nx1;
    if (w_rd_en) begin
      wq <= int'(w_addr);
      xq <= int'(x_sel);
    end
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic calc();
    for (int n = 0; n < OUTL; n++) begin
      longint s = 0;
      for (int i = 0; i < INL; i++) s += longint'(xv[i]) * longint'(wv[n][i]);
      expv[n] = s;
    end
  endtask
  task automatic fill_rand();
    for (int i = 0; i < INL; i++) xv[i] = int'($urandom % 256);
    for (int n = 0; n < OUTL; n++)
      for (int i = 0; i < INL; i++) wv[n][i] = int'($urandom % 256) - 128;
  endtask
  task automatic fill_const(input int xc, input int wc);
    for (int i = 0; i < INL; i++) xv[i] = xc;
    for (int n = 0; n < OUTL; n++)
      for (int i = 0; i < INL; i++) wv[n][i] = wc;
  endtask
  task automatic run_layer(input int mode);
    calc();
    @(negedge clk);
    for (int j = 0; j <= N + 6; j++) begin
      bit iss, rv;
      int idx, n;
      if (j > 0) @(negedge clk);
      iss = (j >= 1 && j <= N) || (mode == 2 && j == N + 6);
      idx = j == N + 6 ? 0 : j - 1;
      n = (j - 3) / CH - 1;
      rv = j >= 3 + CH && (j - 3) % CH == 0 && n < OUTL;
      chk($sformatf("w_rd_en@%0d", j), w_rd_en, iss);
      if (iss) begin
        chk($sformatf("w_addr@%0d", j), w_addr, idx);
        chk($sformatf("x_sel@%0d", j), x_sel, idx % CH);
      end
      chk($sformatf("mult_ena@%0d", j), mult_ena, j >= 2 && j <= N + 1);
      chk($sformatf("busy@%0d", j), busy, iss || (j >= 1 && j <= N + 3));
      chk($sformatf("done@%0d", j), done, j == N + 4);
      chk($sformatf("res_valid@%0d", j), res_valid, rv);
      if (rv) begin
        chk($sformatf("res_idx@%0d", j), res_idx, n);
        chk($sformatf("res_data@%0d", j), $signed(res_data), expv[n]);
      end
      start = j == 0 || mode == 2 || (mode == 1 && j <= N + 4 && $urandom % 2 == 1);
    end
  endtask
  task automatic abort_run();
    @(negedge clk);
    for (int j = 0; j <= N + 8; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 21) begin
        chk("abort_w_rd_en", w_rd_en, 0);
        chk("abort_w_addr", w_addr, 0);
        chk("abort_x_sel", x_sel, 0);
        chk("abort_mult_ena", mult_ena, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_res_idx", res_idx, 0);
      end
      if (j >= 21) begin
        chk($sformatf("abort_valid@%0d", j), res_valid, 0);
        chk($sformatf("abort_done@%0d", j), done, 0);
        chk($sformatf("abort_busy@%0d", j), busy, 0);
      end
      start = j == 0;
      rst = j == 20;
    end
  endtask
  task automatic run_small();
    @(negedge clk);
    for (int j = 0; j <= 7; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("s_w_rd_en@%0d", j), w_rd_en1, j == 1);
      if (j == 1) chk("s_w_addr", w_addr1, 0);
      chk($sformatf("s_busy@%0d", j), busy1, j >= 1 && j <= 4);
      chk($sformatf("s_valid@%0d", j), res_valid1, j == 4);
      if (j == 4) begin
        chk("s_data", $signed(res_data1), 96);
        chk("s_idx", res_idx1, 0);
      end
      chk($sformatf("s_done@%0d", j), done1, j == 5);
      start1 = j == 0;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_rd_en", w_rd_en, 0);
    chk("rst_mult_ena", mult_ena, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_valid1", res_valid1, 0);
    rst = 0;
    fill_const(1, 1);
    run_layer(0);
    fill_const(255, -128);
    run_layer(0);
    fill_const(255, 127);
    run_layer(0);
    for (int i = 0; i < INL; i++) xv[i] = i;
    for (int n = 0; n < OUTL; n++)
      for (int i = 0; i < INL; i++) wv[n][i] = n - 5;
    run_layer(1);
    fill_rand();
    run_layer(2);
    start = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    abort_run();
    fill_rand();
    run_layer(0);
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run_layer(int'($urandom % 2));
    end
    run_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
